simd_bus_ctrl: RTL and testbench
================================

Name: simd_bus_ctrl

Overview:
- Sequencer between the pico 8-bit parallel bus (CS/WR/RD/CD/excute) and the SIMD lane datapath.
- Synchronises the asynchronous pico strobes and decodes address and data write phases into register-file writes for operand bank A, operand bank B and the mode register.
- Launches execution, watches for completion or timeout, then streams lane results back out byte-by-byte on successive RD strobes.

Parameters:
LANES, 32, number of SIMD lanes; bank A at addr 0..LANES-1, bank B at 32..32+LANES-1 (LANES<=32)
RES_BYTES, 2, bytes per lane result, read LSB first
TIMEOUT, 1023, max clk cycles in EXEC waiting for dp_done

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
CS  in  1  pico chip select, active high, asynchronous
WR  in  1  pico write strobe, rising edge acts, asynchronous
RD  in  1  pico read-advance strobe, rising edge acts, asynchronous
CD  in  1  1 = address phase, 0 = data phase
excute  in  1  pico execute strobe, rising edge acts
direction  in  1  pico bus direction, 1 = FPGA drives
pico_din  in  8  bus data from pico
pico_dout  out  8  bus data to pico
pico_oe  out  1  tri-state enable for pico_dout
reg_we  out  1  one-cycle operand/mode write pulse
reg_addr  out  7  write address
reg_wdata  out  8  write data
mode  out  2  current op: 0 a+b, 1 a*b, 2 a*b+c, 3 reserved (passed through)
start  out  1  one-cycle datapath launch pulse
dp_done  in  1  one-cycle datapath completion pulse
busy  out  1  high in EXEC and READ
res_lane  out  5  lane index of result being read
res_data  in  8*RES_BYTES  combinational result of lane res_lane
err  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0; state IDLE; addr_reg=0; rptr=0; sync flops 0.
- Sync: CS, WR, RD, CD, excute, direction and pico_din each pass through 2 flops.
- A third WR/RD/excute flop gives rising-edge detection; one-cycle strobe 3 clk after the pin edge.
- CS, CD and data are sampled from the aligned stage-2 values.
- Every strobe with CS_sync=0 is ignored.
- IDLE, WR strobe, CD=1: addr_reg <= din[6:0].
- IDLE, WR strobe, CD=0, valid addr (bank A, bank B or 64): next cycle reg_we=1, reg_addr=addr_reg, reg_wdata=din.
- Mode write (addr 64): mode <= din[1:0]; addr_reg unchanged.
- Bank write: addr_reg increments; last address of a bank wraps to that bank's base (31 wraps to 0, 63 wraps to 32).
- Invalid-addr data write: no reg_we; err <= 1.
- IDLE, excute strobe: start=1 for one cycle; state EXEC; busy=1; timer=0.
- EXEC:
  - dp_done -> state READ, rptr=0.
  - timer reaching TIMEOUT -> err <= 1, state IDLE, busy=0.
  - dp_done in the same cycle as timeout: dp_done wins.
- READ:
  - res_lane = rptr / RES_BYTES.
  - pico_dout registered = byte (rptr mod RES_BYTES) of res_data; valid 1 clk after rptr changes.
  - pico_oe = CS_sync & direction_sync.
  - RD strobe: rptr++.
  - After strobe number LANES*RES_BYTES: rptr=0, state IDLE, busy=0, pico_oe=0.
- WR or excute strobes in EXEC/READ: ignored and err <= 1.
- RD strobe in IDLE/EXEC: ignored, no error.
- err cleared only by rst.
- WR and excute strobes in the same cycle in IDLE: write processed, excute ignored.
- rst asserted mid-operation: immediate return to reset state.
- Bank and mode contents live in the datapath and are not cleared here.

Test Plan:
- CS=0, CD=1 WR then CD=0 WR with 0xFF -> no reg_we, err=0.
- CS=1: addr 64, data 1 -> reg_we pulse at reg_addr=64 with reg_wdata=1; mode=1; err=0.
- addr 0, then data 2,3,4 -> reg_we at addr 0,1,2 with data 2,3,4.
- addr 31, data 9, data 10 -> writes at 31 then 0 (bank wrap).
- addr 32 -> 5, 33 -> 6, 34 -> 7 -> writes land at 32,33,34.
- addr 100, data 5 -> no reg_we; err=1.
- excute -> start pulse ~3 clk later; busy=1. dp_done after 20 clk -> READ.
- In READ, 64 RD strobes with res_data=0x00LL (LL=lane) -> pico_dout sequence 00,00,01,00,…,1F,00.
- After the 64th strobe: busy=0, pico_oe=0.
- excute with no dp_done -> after TIMEOUT+1 clk: state IDLE, busy=0, err=1.
- rst pulse mid-READ -> all outputs 0; a following RD strobe has no effect.

Source files
------------

// File: rtl/simd_bus_if.sv
// Bundles the pico parallel-bus pins and the SIMD datapath handshake of the bus sequencer.
// The master side is the pico/datapath environment; the slave side is simd_bus_ctrl.
interface simd_bus_if #(
    parameter int RES_BYTES = 2
);
    logic                   CS;
    logic                   WR;
    logic                   RD;
    logic                   CD;
    logic                   excute;
    logic                   direction;
    logic [7:0]             pico_din;
    logic [7:0]             pico_dout;
    logic                   pico_oe;
    logic                   reg_we;
    logic [6:0]             reg_addr;
    logic [7:0]             reg_wdata;
    logic [1:0]             mode;
    logic                   start;
    logic                   dp_done;
    logic                   busy;
    logic [4:0]             res_lane;
    logic [8*RES_BYTES-1:0] res_data;
    logic                   err;

    modport slave (
        input  CS, WR, RD, CD, excute, direction, pico_din, dp_done, res_data,
        output pico_dout, pico_oe, reg_we, reg_addr, reg_wdata, mode, start, busy, res_lane, err
    );

    modport master (
        output CS, WR, RD, CD, excute, direction, pico_din, dp_done, res_data,
        input  pico_dout, pico_oe, reg_we, reg_addr, reg_wdata, mode, start, busy, res_lane, err
    );
endinterface

// File: rtl/simd_bus_ctrl.sv
// Pico bus sequencer for the SIMD lanes: synchronises the pico strobes, turns bus writes into
// register-file writes, launches the datapath and streams lane results back byte by byte.
module simd_bus_ctrl #(
    parameter int LANES     = 32,
    parameter int RES_BYTES = 2,
    parameter int TIMEOUT   = 1023
) (
    input  logic      clk,
    input  logic      rst,
    simd_bus_if.slave bus
);
    localparam int RPW = $clog2(LANES * RES_BYTES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);
    localparam logic [RPW-1:0] RPTR_LAST = RPW'(LANES * RES_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        READ = 2'd2
    } state_t;

    state_t         state_r, state_s;
    logic [1:0]     cs_sync_r, cd_sync_r, dir_sync_r;
    logic [2:0]     wr_sync_r, rd_sync_r, ex_sync_r;
    logic [7:0]     din_meta_r, din_sync_r;
    logic [6:0]     addr_r, addr_s;
    logic [TW-1:0]  timer_r, timer_s;
    logic [RPW-1:0] rptr_r, rptr_s;
    logic [1:0]     mode_r, mode_s;
    logic           err_r, err_s;
    logic           we_r, we_s;
    logic [6:0]     waddr_r, waddr_s;
    logic [7:0]     wdata_r, wdata_s;
    logic           start_r, start_s;
    logic           busy_r, busy_s;
    logic           oe_r, oe_s;
    logic [7:0]     dout_r, dout_s;
    logic [4:0]     lane_r;
    logic [7:0]     lane_full_s;
    logic           wr_stb_s, rd_stb_s, ex_stb_s;
    logic           bank_a_s, bank_b_s, is_mode_s;

    function automatic logic [7:0] byte_sel(input logic [8*RES_BYTES-1:0] data,
                                            input logic [RPW-1:0] idx);
        logic [8*RES_BYTES-1:0] shifted;
        shifted = data >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

    // Two-flop synchronisers; the strobe lines get a third flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_sync_r  <= 2'b00;
            cd_sync_r  <= 2'b00;
            dir_sync_r <= 2'b00;
            wr_sync_r  <= 3'b000;
            rd_sync_r  <= 3'b000;
            ex_sync_r  <= 3'b000;
            din_meta_r <= 8'h00;
            din_sync_r <= 8'h00;
        end else begin
            cs_sync_r  <= {cs_sync_r[0], bus.CS};
            cd_sync_r  <= {cd_sync_r[0], bus.CD};
            dir_sync_r <= {dir_sync_r[0], bus.direction};
            wr_sync_r  <= {wr_sync_r[1:0], bus.WR};
            rd_sync_r  <= {rd_sync_r[1:0], bus.RD};
            ex_sync_r  <= {ex_sync_r[1:0], bus.excute};
            din_meta_r <= bus.pico_din;
            din_sync_r <= din_meta_r;
        end
    end

    assign wr_stb_s  = cs_sync_r[1] & wr_sync_r[1] & ~wr_sync_r[2];
    assign rd_stb_s  = cs_sync_r[1] & rd_sync_r[1] & ~rd_sync_r[2];
    assign ex_stb_s  = cs_sync_r[1] & ex_sync_r[1] & ~ex_sync_r[2];
    assign bank_a_s  = (addr_r < 7'(LANES));
    assign bank_b_s  = (addr_r >= 7'd32) && (addr_r < 7'(32 + LANES));
    assign is_mode_s = (addr_r == 7'd64);

    // Next-state and next-output decode; a write strobe takes priority over execute in IDLE.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        timer_s = timer_r;
        rptr_s  = rptr_r;
        mode_s  = mode_r;
        err_s   = err_r;
        we_s    = 1'b0;
        waddr_s = waddr_r;
        wdata_s = wdata_r;
        start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (wr_stb_s) begin
                    if (cd_sync_r[1]) begin
                        addr_s = din_sync_r[6:0];
                    end else if (bank_a_s || bank_b_s || is_mode_s) begin
                        we_s    = 1'b1;
                        waddr_s = addr_r;
                        wdata_s = din_sync_r;
                        if (is_mode_s) begin
                            mode_s = din_sync_r[1:0];
                        end else if (addr_r == 7'(LANES - 1)) begin
                            addr_s = 7'd0;
                        end else if (addr_r == 7'(32 + LANES - 1)) begin
                            addr_s = 7'd32;
                        end else begin
                            addr_s = addr_r + 7'd1;
                        end
                    end else begin
                        err_s = 1'b1;
                    end
                end else if (ex_stb_s) begin
                    start_s = 1'b1;
                    state_s = EXEC;
                    timer_s = '0;
                end else begin
                    state_s = IDLE;
                end
            end
            EXEC: begin
                if (wr_stb_s || ex_stb_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                // Completion beats a timeout landing in the same cycle.
                if (bus.dp_done) begin
                    state_s = READ;
                    rptr_s  = '0;
                end else if (timer_r == TW'(TIMEOUT)) begin
                    err_s   = 1'b1;
                    state_s = IDLE;
                end else begin
                    timer_s = timer_r + TW'(1);
                end
            end
            READ: begin
                if (wr_stb_s || ex_stb_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = err_r;
                end
                if (rd_stb_s) begin
                    if (rptr_r == RPTR_LAST) begin
                        rptr_s  = '0;
                        state_s = IDLE;
                    end else begin
                        rptr_s = rptr_r + RPW'(1);
                    end
                end else begin
                    rptr_s = rptr_r;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s      = (state_s != IDLE);
        oe_s        = (state_s == READ) & cs_sync_r[1] & dir_sync_r[1];
        lane_full_s = 8'(rptr_s / RPW'(RES_BYTES));
        if (state_r == READ) begin
            dout_s = byte_sel(bus.res_data, rptr_r % RPW'(RES_BYTES));
        end else begin
            dout_s = 8'h00;
        end
    end

    // Sequencer state and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            addr_r  <= 7'd0;
            timer_r <= '0;
            rptr_r  <= '0;
            mode_r  <= 2'd0;
            err_r   <= 1'b0;
            we_r    <= 1'b0;
            waddr_r <= 7'd0;
            wdata_r <= 8'h00;
            start_r <= 1'b0;
            busy_r  <= 1'b0;
            oe_r    <= 1'b0;
            dout_r  <= 8'h00;
            lane_r  <= 5'd0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            timer_r <= timer_s;
            rptr_r  <= rptr_s;
            mode_r  <= mode_s;
            err_r   <= err_s;
            we_r    <= we_s;
            waddr_r <= waddr_s;
            wdata_r <= wdata_s;
            start_r <= start_s;
            busy_r  <= busy_s;
            oe_r    <= oe_s;
            dout_r  <= dout_s;
            lane_r  <= lane_full_s[4:0];
        end
    end

    assign bus.pico_dout = dout_r;
    assign bus.pico_oe   = oe_r;
    assign bus.reg_we    = we_r;
    assign bus.reg_addr  = waddr_r;
    assign bus.reg_wdata = wdata_r;
    assign bus.mode      = mode_r;
    assign bus.start     = start_r;
    assign bus.busy      = busy_r;
    assign bus.res_lane  = lane_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_simd_bus_ctrl.sv
// Self-checking bench for simd_bus_ctrl: register writes and read-back bytes go through scoreboards.
module tb_simd_bus_ctrl;
    localparam int LANES     = 32;
    localparam int RES_BYTES = 2;
    localparam int TIMEOUT   = 1023;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    simd_bus_if #(.RES_BYTES(RES_BYTES)) bus ();

    simd_bus_ctrl #(.LANES(LANES), .RES_BYTES(RES_BYTES), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Lane result model: low byte is the lane index, high byte zero.
    assign bus.res_data = {8'h00, 3'b000, bus.res_lane};

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [14:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [14:0] wr_exp;
    int          start_cnt = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-port monitor: every reg_we cycle must match the next queued write.
    always @(negedge clk) begin
        if (!rst && bus.start) start_cnt++;
        if (!rst && bus.reg_we) begin
            if (wr_q.size() == 0) begin
                check_eq("we_unexpected", {25'd0, bus.reg_addr}, 32'hFFFF_FFFF);
            end else begin
                wr_exp = wr_q.pop_front();
                check_eq("we_addr", {25'd0, bus.reg_addr}, {25'd0, wr_exp[14:8]});
                check_eq("we_data", {24'd0, bus.reg_wdata}, {24'd0, wr_exp[7:0]});
            end
        end
    end

    task automatic strobe_wr(input logic cd, input logic [7:0] d);
        bus.CD       = cd;
        bus.pico_din = d;
        repeat (2) @(negedge clk);
        bus.WR = 1'b1;
        repeat (4) @(negedge clk);
        bus.WR = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic strobe_rd();
        bus.RD = 1'b1;
        repeat (4) @(negedge clk);
        bus.RD = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic write_reg(input logic [6:0] a, input logic [7:0] d);
        wr_q.push_back({a, d});
        strobe_wr(1'b0, d);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_data"}, {9'd0, bus.pico_dout, bus.reg_addr, bus.reg_wdata}, 32'd0);
        check_eq({tag, "_ctl"}, {20'd0, bus.pico_oe, bus.reg_we, bus.mode, bus.start,
                                 bus.busy, bus.res_lane, bus.err}, 32'd0);
    endtask

    // Raises excute and returns on the negedge of the cycle that carries start.
    task automatic exec_launch();
        int lat;
        lat = 0;
        bus.excute = 1'b1;
        while (!bus.start && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        bus.excute = 1'b0;
        check_eq("start_latency", lat, 32'd3);
        check_eq("busy_exec", {31'd0, bus.busy}, 32'd1);
    endtask

    task automatic pulse_done();
        bus.dp_done = 1'b1;
        @(negedge clk);
        bus.dp_done = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst           = 1'b1;
        bus.CS        = 1'b0;
        bus.WR        = 1'b0;
        bus.RD        = 1'b0;
        bus.CD        = 1'b0;
        bus.excute    = 1'b0;
        bus.direction = 1'b0;
        bus.pico_din  = 8'h00;
        bus.dp_done   = 1'b0;
        do_reset();
        check_reset_outputs("reset");

        // Chip select low: both phases ignored.
        strobe_wr(1'b1, 8'h05);
        strobe_wr(1'b0, 8'hFF);
        check_eq("cs0_err", {31'd0, bus.err}, 32'd0);

        bus.CS        = 1'b1;
        bus.direction = 1'b1;
        strobe_wr(1'b1, 8'd64);
        write_reg(7'd64, 8'd1);
        check_eq("mode", {30'd0, bus.mode}, 32'd1);
        check_eq("mode_err", {31'd0, bus.err}, 32'd0);

        strobe_wr(1'b1, 8'd0);
        for (int i = 0; i < 3; i++) write_reg(7'(i), 8'(2 + i));
        strobe_wr(1'b1, 8'd31);
        write_reg(7'd31, 8'd9);
        write_reg(7'd0, 8'd10);
        strobe_wr(1'b1, 8'd32);
        for (int i = 0; i < 3; i++) write_reg(7'(32 + i), 8'(5 + i));
        strobe_wr(1'b1, 8'd63);
        write_reg(7'd63, 8'd1);
        write_reg(7'd32, 8'd2);
        check_eq("wr_q_drained", wr_q.size(), 32'd0);

        strobe_wr(1'b1, 8'd100);
        strobe_wr(1'b0, 8'd5);
        check_eq("bad_addr_err", {31'd0, bus.err}, 32'd1);

        // Execute, complete after 20 clocks, then read all 64 result bytes.
        exec_launch();
        repeat (20) @(negedge clk);
        check_eq("busy_before_done", {31'd0, bus.busy}, 32'd1);
        pulse_done();
        check_eq("oe_read", {31'd0, bus.pico_oe}, 32'd1);
        for (int k = 0; k < LANES * RES_BYTES; k++) begin
            rd_q.push_back((k % 2 == 0) ? 8'(k / 2) : 8'h00);
            check_eq($sformatf("rd_byte%0d", k), {24'd0, bus.pico_dout}, {24'd0, rd_q.pop_front()});
            strobe_rd();
        end
        check_eq("busy_after_read", {31'd0, bus.busy}, 32'd0);
        check_eq("oe_after_read", {31'd0, bus.pico_oe}, 32'd0);
        check_eq("start_count", start_cnt, 32'd1);

        // Timeout: busy for exactly TIMEOUT+1 cycles, then error.
        do_reset();
        check_eq("err_cleared", {31'd0, bus.err}, 32'd0);
        exec_launch();
        repeat (TIMEOUT) @(negedge clk);
        check_eq("busy_pre_timeout", {31'd0, bus.busy}, 32'd1);
        check_eq("err_pre_timeout", {31'd0, bus.err}, 32'd0);
        @(negedge clk);
        check_eq("busy_timeout", {31'd0, bus.busy}, 32'd0);
        check_eq("err_timeout", {31'd0, bus.err}, 32'd1);

        // Reset mid-READ, after a stray write strobe flags an error.
        do_reset();
        exec_launch();
        repeat (5) @(negedge clk);
        pulse_done();
        strobe_rd();
        strobe_rd();
        check_eq("mid_lane", {27'd0, bus.res_lane}, 32'd1);
        check_eq("mid_dout", {24'd0, bus.pico_dout}, 32'd1);
        strobe_wr(1'b0, 8'h33);
        check_eq("wr_in_read_err", {31'd0, bus.err}, 32'd1);
        check_eq("wr_in_read_busy", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        strobe_rd();
        check_reset_outputs("rd_after_rst");
        check_eq("wr_q_final", wr_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
